// File: rtl/fetch_stage.sv
// -----------------------------------------------------------------------------
// fetch_stage
//
// Y86-64 style pipelined fetch stage. Decodes the ten instruction bytes
// presented at f_pc, computes the fall-through address (valP) and the
// predicted next PC, and registers the fetched fields into the decode-stage
// pipeline register (D_*). F_predPC is the only other state held.
//
// Parameters
//   RESET_PC    value loaded into F_predPC on reset
//
// Ports
//   clk         single clock, all state updates on the rising edge
//   rst_n       synchronous active-low reset
//   f_pc        fetch address chosen by the PC-select stage
//   imem_data   ten bytes at f_pc, byte k at [8k+7:8k]
//   imem_error  instruction memory address fault for this fetch
//   F_stall     hold F_predPC
//   D_stall     hold the whole D register (wins over D_bubble)
//   D_bubble    load a nop bubble into the D register
//   imem_addr   instruction memory address (= f_pc, combinational)
//   F_predPC    registered predicted next PC
//   D_stat, D_icode, D_ifun, D_rA, D_rB, D_valC, D_valP
//               registered decode-stage pipeline register
// -----------------------------------------------------------------------------
module fetch_stage #(
    parameter logic [63:0] RESET_PC = 64'h0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [63:0] f_pc,
    input  logic [79:0] imem_data,
    input  logic        imem_error,
    input  logic        F_stall,
    input  logic        D_stall,
    input  logic        D_bubble,
    output logic [63:0] imem_addr,
    output logic [63:0] F_predPC,
    output logic [2:0]  D_stat,
    output logic [3:0]  D_icode,
    output logic [3:0]  D_ifun,
    output logic [3:0]  D_rA,
    output logic [3:0]  D_rB,
    output logic [63:0] D_valC,
    output logic [63:0] D_valP
);

    // Status codes
    localparam logic [2:0] STAT_AOK = 3'd1;
    localparam logic [2:0] STAT_HLT = 3'd2;
    localparam logic [2:0] STAT_ADR = 3'd3;
    localparam logic [2:0] STAT_INS = 3'd4;

    // Instruction codes
    localparam logic [3:0] I_HALT   = 4'h0;
    localparam logic [3:0] I_NOP    = 4'h1;
    localparam logic [3:0] I_RRMOVQ = 4'h2;
    localparam logic [3:0] I_IRMOVQ = 4'h3;
    localparam logic [3:0] I_RMMOVQ = 4'h4;
    localparam logic [3:0] I_MRMOVQ = 4'h5;
    localparam logic [3:0] I_OPQ    = 4'h6;
    localparam logic [3:0] I_JXX    = 4'h7;
    localparam logic [3:0] I_CALL   = 4'h8;
    localparam logic [3:0] I_PUSHQ  = 4'hA;
    localparam logic [3:0] I_POPQ   = 4'hB;

    localparam logic [3:0] R_NONE   = 4'hF;

    // Fetched (pre-register) fields
    logic [3:0]  f_icode;
    logic [3:0]  f_ifun;
    logic        instr_valid;
    logic        need_regids;
    logic        need_valc;
    logic [3:0]  f_ra;
    logic [3:0]  f_rb;
    logic [63:0] f_valc;
    logic [63:0] f_valp;
    logic [63:0] f_pred_pc;
    logic [2:0]  f_stat;

    assign imem_addr = f_pc;

    // NOTE: every signal written in this block gets a default first, so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        f_icode     = imem_data[7:4];
        f_ifun      = imem_data[3:0];
        need_regids = 1'b0;
        need_valc   = 1'b0;
        f_ra        = R_NONE;
        f_rb        = R_NONE;
        f_valc      = 64'd0;

        // A faulting fetch is turned into a nop; everything downstream
        // (register ids, constant, valP) is then derived from that nop.
        if (imem_error) begin
            f_icode = I_NOP;
            f_ifun  = 4'h0;
        end

        instr_valid = (f_icode <= I_POPQ);

        case (f_icode)
            I_RRMOVQ, I_OPQ, I_PUSHQ, I_POPQ: need_regids = 1'b1;
            I_IRMOVQ, I_RMMOVQ, I_MRMOVQ: begin
                need_regids = 1'b1;
                need_valc   = 1'b1;
            end
            I_JXX, I_CALL: need_valc = 1'b1;
            default: ;
        endcase

        if (need_regids) begin
            f_ra = imem_data[15:12];
            f_rb = imem_data[11:8];
        end

        // Constant sits right after the register byte when there is one.
        if (need_valc) begin
            f_valc = need_regids ? imem_data[79:16] : imem_data[71:8];
        end

        // Wraps modulo 2^64 by construction.
        f_valp = f_pc + 64'd1 + {63'd0, need_regids}
                      + (need_valc ? 64'd8 : 64'd0);

        f_pred_pc = (f_icode == I_JXX || f_icode == I_CALL) ? f_valc : f_valp;

        if (imem_error) begin
            f_stat = STAT_ADR;
        end else if (!instr_valid) begin
            f_stat = STAT_INS;
        end else if (f_icode == I_HALT) begin
            f_stat = STAT_HLT;
        end else begin
            f_stat = STAT_AOK;
        end
    end

    // NOTE: non-blocking assignments so every register samples the values
    // present before the edge, independent of statement order.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            F_predPC <= RESET_PC;
            D_stat   <= STAT_AOK;
            D_icode  <= I_NOP;
            D_ifun   <= 4'h0;
            D_rA     <= R_NONE;
            D_rB     <= R_NONE;
            D_valC   <= 64'd0;
            D_valP   <= 64'd0;
        end else begin
            if (!F_stall) begin
                F_predPC <= f_pred_pc;
            end

            // Stall outranks bubble: the D register simply holds.
            if (!D_stall) begin
                if (D_bubble) begin
                    D_stat  <= STAT_AOK;
                    D_icode <= I_NOP;
                    D_ifun  <= 4'h0;
                    D_rA    <= R_NONE;
                    D_rB    <= R_NONE;
                    D_valC  <= 64'd0;
                    D_valP  <= 64'd0;
                end else begin
                    D_stat  <= f_stat;
                    D_icode <= f_icode;
                    D_ifun  <= f_ifun;
                    D_rA    <= f_ra;
                    D_rB    <= f_rb;
                    D_valC  <= f_valc;
                    D_valP  <= f_valp;
                end
            end
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// -----------------------------------------------------------------------------
// tb_fetch_stage
//
// Self-checking bench for fetch_stage: directed instruction scenarios followed
// by randomized fetches, stalls, bubbles, faults and resets, all compared
// against a byte-level reference model of the fetch rules.
// -----------------------------------------------------------------------------
module tb_fetch_stage;

    localparam logic [63:0] RESET_PC = 64'h0;

    typedef struct packed {
        logic [2:0]  stat;
        logic [3:0]  icode;
        logic [3:0]  ifun;
        logic [3:0]  ra;
        logic [3:0]  rb;
        logic [63:0] valc;
        logic [63:0] valp;
    } dreg_t;

    localparam dreg_t BUBBLE = '{stat: 3'd1, icode: 4'h1, ifun: 4'h0,
                                 ra: 4'hF, rb: 4'hF, valc: 64'd0, valp: 64'd0};

    logic        clk;
    logic        rst_n;
    logic [63:0] f_pc;
    logic [79:0] imem_data;
    logic        imem_error;
    logic        F_stall;
    logic        D_stall;
    logic        D_bubble;
    logic [63:0] imem_addr;
    logic [63:0] F_predPC;
    logic [2:0]  D_stat;
    logic [3:0]  D_icode;
    logic [3:0]  D_ifun;
    logic [3:0]  D_rA;
    logic [3:0]  D_rB;
    logic [63:0] D_valC;
    logic [63:0] D_valP;

    int compared   = 0;
    int mismatched = 0;

    dreg_t       exp_d;
    logic [63:0] exp_pred;

    fetch_stage #(.RESET_PC(RESET_PC)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .f_pc       (f_pc),
        .imem_data  (imem_data),
        .imem_error (imem_error),
        .F_stall    (F_stall),
        .D_stall    (D_stall),
        .D_bubble   (D_bubble),
        .imem_addr  (imem_addr),
        .F_predPC   (F_predPC),
        .D_stat     (D_stat),
        .D_icode    (D_icode),
        .D_ifun     (D_ifun),
        .D_rA       (D_rA),
        .D_rB       (D_rB),
        .D_valC     (D_valC),
        .D_valP     (D_valP)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs,
                         input logic [63:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference model: what one fetch of the ten bytes at pc should produce.
    function automatic void model_fetch(input logic [63:0] pc,
                                        input logic [79:0] data,
                                        input logic err,
                                        output dreg_t d,
                                        output logic [63:0] pred);
        logic [7:0] b [10];
        logic [3:0] icode;
        logic       regs;
        logic       cval;
        int         first;
        for (int k = 0; k < 10; k++) b[k] = data[8*k +: 8];
        icode  = err ? 4'h1 : b[0][7:4];
        d.icode = icode;
        d.ifun  = err ? 4'h0 : b[0][3:0];
        regs   = icode inside {4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'hA, 4'hB};
        cval   = icode inside {4'h3, 4'h4, 4'h5, 4'h7, 4'h8};
        d.ra   = regs ? b[1][7:4] : 4'hF;
        d.rb   = regs ? b[1][3:0] : 4'hF;
        first  = regs ? 2 : 1;
        d.valc = 64'd0;
        if (cval)
            for (int k = 0; k < 8; k++)
                d.valc = d.valc | (64'(b[first + k]) << (8 * k));
        d.valp = pc + 64'd1 + (regs ? 64'd1 : 64'd0) + (cval ? 64'd8 : 64'd0);
        if (err)             d.stat = 3'd3;
        else if (icode > 11) d.stat = 3'd4;
        else if (icode == 0) d.stat = 3'd2;
        else                 d.stat = 3'd1;
        pred = (icode == 4'h7 || icode == 4'h8) ? d.valc : d.valp;
    endfunction

    task automatic check_all(input string tag);
        check({tag, ".F_predPC"}, F_predPC, exp_pred);
        check({tag, ".D_stat"},   64'(D_stat),  64'(exp_d.stat));
        check({tag, ".D_icode"},  64'(D_icode), 64'(exp_d.icode));
        check({tag, ".D_ifun"},   64'(D_ifun),  64'(exp_d.ifun));
        check({tag, ".D_rA"},     64'(D_rA),    64'(exp_d.ra));
        check({tag, ".D_rB"},     64'(D_rB),    64'(exp_d.rb));
        check({tag, ".D_valC"},   D_valC, exp_d.valc);
        check({tag, ".D_valP"},   D_valP, exp_d.valp);
    endtask

    // One clock: drive inputs on the falling edge, advance the model at the
    // rising edge, compare every output 1 time unit later.
    task automatic step(input string tag, input logic rst, input logic fs,
                        input logic ds, input logic db, input logic err,
                        input logic [63:0] pc, input logic [79:0] data);
        dreg_t       f;
        logic [63:0] p;
        @(negedge clk);
        rst_n      = rst;
        F_stall    = fs;
        D_stall    = ds;
        D_bubble   = db;
        imem_error = err;
        f_pc       = pc;
        imem_data  = data;
        #1;
        check({tag, ".imem_addr"}, imem_addr, pc);
        model_fetch(pc, data, err, f, p);
        @(posedge clk);
        #1;
        if (!rst) begin
            exp_pred = RESET_PC;
            exp_d    = BUBBLE;
        end else begin
            if (!fs) exp_pred = p;
            if (!ds) exp_d = db ? BUBBLE : f;
        end
        check_all(tag);
    endtask

    initial begin
        logic [63:0] rpc;
        logic [79:0] rdata;
        rst_n = 1'b0; F_stall = 1'b0; D_stall = 1'b0; D_bubble = 1'b0;
        imem_error = 1'b0; f_pc = 64'd0; imem_data = 80'd0;
        exp_d = BUBBLE; exp_pred = RESET_PC;

        // Reset for two cycles with every hazard strobe asserted.
        step("reset0", 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 64'h1234, 80'h30F2);
        step("reset1", 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 64'h5678, 80'h80);
        check("reset.F_predPC", F_predPC, 64'h0);
        check("reset.D_icode", 64'(D_icode), 64'h1);
        check("reset.D_stat",  64'(D_stat),  64'h1);
        check("reset.D_rA",    64'(D_rA),    64'hF);
        check("reset.D_rB",    64'(D_rB),    64'hF);

        // irmovq $8, %rdx at 0x100
        step("irmovq", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 64'h100, 80'h08F230);
        check("irmovq.icode", 64'(D_icode), 64'h3);
        check("irmovq.rB",    64'(D_rB),    64'h2);
        check("irmovq.valC",  D_valC,   64'h8);
        check("irmovq.valP",  D_valP,   64'h10A);
        check("irmovq.pred",  F_predPC, 64'h10A);

        // call 0x40 at 0x20
        step("call", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 64'h20, 80'h4080);
        check("call.valC", D_valC,   64'h40);
        check("call.valP", D_valP,   64'h29);
        check("call.pred", F_predPC, 64'h40);

        // Stall and bubble together: D holds the call.
        step("stall_bub", 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 64'h300, 80'h1260);
        check("stall_bub.icode", 64'(D_icode), 64'h8);
        check("stall_bub.valC",  D_valC, 64'h40);
        check("stall_bub.pred",  F_predPC, 64'h302);

        // Bubble alone.
        step("bubble", 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 64'h400, 80'h10);
        check("bubble.icode", 64'(D_icode), 64'h1);
        check("bubble.valP",  D_valP, 64'h0);

        // F_stall holds the predicted PC.
        step("fstall", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 64'h500, 80'h10);
        check("fstall.pred", F_predPC, 64'h401);
        check("fstall.valP", D_valP,   64'h501);

        // Status cases.
        step("ins", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 64'h600, 80'hC0);
        check("ins.stat", 64'(D_stat), 64'h4);
        step("adr", 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 64'h700, 80'h08F230);
        check("adr.stat",  64'(D_stat),  64'h3);
        check("adr.icode", 64'(D_icode), 64'h1);
        step("hlt", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 64'h800, 80'h00);
        check("hlt.stat", 64'(D_stat), 64'h2);
        check("hlt.valP", D_valP, 64'h801);

        // ret at the top of the address space wraps.
        step("wrap", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 80'h90);
        check("wrap.valP", D_valP,   64'h0);
        check("wrap.pred", F_predPC, 64'h0);

        // Reset mid-stream, then the first fetch uses f_pc as supplied.
        step("midrst", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 64'h900, 80'h4080);
        step("postrst", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 64'hA00, 80'h10);
        check("postrst.valP", D_valP, 64'hA01);

        // Randomized traffic.
        for (int i = 0; i < 400; i++) begin
            rpc   = {$urandom, $urandom};
            if ($urandom_range(0, 9) == 0) rpc = 64'hFFFF_FFFF_FFFF_FFF0 | 64'($urandom_range(0, 15));
            rdata = {16'($urandom), $urandom, $urandom};
            step("rand",
                 $urandom_range(0, 39) != 0,
                 $urandom_range(0, 3) == 0,
                 $urandom_range(0, 4) == 0,
                 $urandom_range(0, 4) == 0,
                 $urandom_range(0, 9) == 0,
                 rpc, rdata);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 SHALL have parameter RESET_PC, default 64'h0, value loaded into F_predPC on reset.
REQ-002 SHALL have port clk, input, 1, single clock; all state updates on rising edge.
REQ-003 SHALL have port rst_n, input, 1; reset is synchronous and active-low.
REQ-004 SHALL have port f_pc, input, 64, fetch address chosen by the PC-select stage.
REQ-005 SHALL have port imem_data, input, 80, ten bytes at f_pc; byte k at [8k+7:8k].
REQ-006 SHALL have port imem_error, input, 1, instruction memory address fault.
REQ-007 SHALL have ports F_stall, D_stall and D_bubble, input, 1 each, hazard-control strobes.
REQ-008 SHALL have port imem_addr, output, 64, equal to f_pc (combinational).
REQ-009 SHALL have port F_predPC, output, 64, registered predicted next PC.
REQ-010 SHALL have ports D_stat (3), D_icode (4), D_ifun (4), D_rA (4), D_rB (4), D_valC (64) and D_valP (64), output, registered decode-stage pipeline register.

Function
REQ-011 SHALL decode byte 0 as icode = [7:4] and ifun = [3:0].
REQ-012 SHALL treat icode 0x0-0xB as valid; any other value flags an invalid instruction.
REQ-013 SHALL assert need_regids for icode 2, 3, 4, 5, 6, A and B; rA = byte1[7:4], rB = byte1[3:0]; otherwise rA = rB = 4'hF.
REQ-014 SHALL assert need_valC for icode 3, 4, 5, 7 and 8; valC = little-endian bytes 2-9 when need_regids, bytes 1-8 otherwise, else 0.
REQ-015 SHALL compute valP = f_pc + 1 + need_regids + 8*need_valC, modulo 2^64 (wrap allowed, no flag).
REQ-016 SHALL compute predicted PC = valC for icode 7 or 8, else valP.
REQ-017 SHALL compute fetch stat with priority: imem_error gives ADR (3'd3); else invalid icode gives INS (3'd4); else icode 0 gives HLT (3'd2); else AOK (3'd1).
REQ-018 SHALL force icode = 1 (nop) and ifun = 0 into the D register when imem_error is high.
REQ-019 SHALL load F_predPC with the predicted PC each cycle unless F_stall = 1, in which case F_predPC holds.
REQ-020 SHALL apply D-register priority: D_stall holds all D outputs; else D_bubble loads the bubble value; else load fetched fields.
REQ-021 SHALL define the bubble value as stat AOK, icode 1, ifun 0, rA = rB = F, valC = valP = 0.
REQ-022 SHALL let D_stall win when D_stall and D_bubble are both high.
REQ-023 SHALL give one-cycle latency from f_pc/imem_data to the D outputs and to F_predPC.
REQ-024 SHALL hold no state other than F_predPC and the D register.

Reset
REQ-025 SHALL, on a rising clk edge with rst_n = 0, load F_predPC = RESET_PC and the D register with the bubble value, regardless of stall or bubble inputs.
REQ-026 SHALL abandon any in-flight fetch when reset is asserted mid-operation; the first fetch after rst_n rises uses f_pc supplied by PC select.

Verification
REQ-027 SHALL cover reset: rst_n = 0 for 2 cycles with F_stall = 1 -> F_predPC = 0, D_icode = 1, D_stat = 1, D_rA = D_rB = F.
REQ-028 SHALL cover irmovq: f_pc = 0x100, bytes 30 F2 08 00 00 00 00 00 00 00 -> next cycle D_icode = 3, D_rB = 2, D_valC = 8, D_valP = 0x10A, F_predPC = 0x10A.
REQ-029 SHALL cover call: f_pc = 0x20, bytes 80 40 00 00 00 00 00 00 00 -> D_valC = 0x40, D_valP = 0x29, F_predPC = 0x40.
REQ-030 SHALL cover stall and bubble: D_stall = 1 with D_bubble = 1 -> D outputs unchanged; then D_bubble = 1 alone -> D_icode = 1, D_valP = 0; F_stall = 1 -> F_predPC held.
REQ-031 SHALL cover status: byte0 = 0xC0 -> D_stat = 4; imem_error = 1 -> D_stat = 3 and D_icode = 1; byte0 = 0x00 -> D_stat = 2 and D_valP = f_pc + 1.
REQ-032 SHALL cover wrap: f_pc = 64'hFFFF_FFFF_FFFF_FFFF with ret (0x90) -> D_valP = 0 and F_predPC = 0.
